// File: rtl/phy_rx_pkg.sv
// Shared types and constants for the phy_rx receive path.
package phy_rx_pkg;

  localparam int         BYTE_W      = 8;
  localparam logic [7:0] COM_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_bit_shifter.sv
// Serial-in shift register with enable. Presents nxt, the byte as it will
// look once the current bit is shifted in, so the aligner can decide on the
// same edge that samples the bit.
//
// Only the low 7 bits of the 8-bit window are stored: the oldest bit is
// always shifted out on the next enabled bit and never observed, and nxt
// rebuilds the full window from the stored bits plus the live input.
module rx_bit_shifter
  import phy_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [BYTE_W-1:0] nxt
);

  logic [BYTE_W-2:0] sr_hist;

  assign nxt = {sr_hist, bit_in};

  // Shift one bit in, MSB first, on each enabled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_hist <= '0;
    end else if (shift_en) begin
      sr_hist <= nxt[BYTE_W-2:0];
    end
  end

endmodule

// File: rtl/rx_serial_to_parallel.sv
// Receive deserializer and COM-symbol aligner feeding the phy_rx lane demux.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SEARCH | sliding-match every enabled bit against COM_SYMBOL
// ALIGN  | boundary fixed; counting consecutive aligned COMs
// ACTIVE | locked; emitting framed bytes (left only by reset)
module rx_serial_to_parallel
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL     = COM_DEFAULT,
  parameter int         COM_LOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  input  logic              data_in_en,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              com_det,
  output logic              active
);

  localparam logic [3:0] LOCK_N = 4'(COM_LOCK_COUNT);

  rx_state_e         state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [3:0]        com_cnt, com_cnt_n;
  logic [BYTE_W-1:0] nxt;
  logic [BYTE_W-1:0] data_out_n;
  logic              valid_out_n;
  logic              com_det_n;
  logic              is_com;
  logic              byte_end;

  rx_bit_shifter u_shifter (
    .clk      (clk),
    .reset    (reset),
    .shift_en (data_in_en),
    .bit_in   (data_in),
    .nxt      (nxt)
  );

  assign is_com   = (nxt == COM_SYMBOL);
  assign byte_end = (bit_cnt == 3'd7);
  assign active   = (state == ACTIVE);

  // State, counters and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      com_det   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      com_cnt   <= com_cnt_n;
      data_out  <= data_out_n;
      valid_out <= valid_out_n;
      com_det   <= com_det_n;
    end
  end

  // Next-state, counter and output decode; idle cycles hold everything.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    com_cnt_n   = com_cnt;
    data_out_n  = data_out;
    valid_out_n = 1'b0;
    com_det_n   = 1'b0;

    if (data_in_en) begin
      case (state)
        SEARCH: begin
          if (is_com) begin
            bit_cnt_n = 3'd0;
            com_cnt_n = 4'd1;
            state_n   = (LOCK_N == 4'd1) ? ACTIVE : ALIGN;
          end
        end

        ALIGN: begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (byte_end) begin
            if (is_com) begin
              if (com_cnt != LOCK_N) begin
                com_cnt_n = com_cnt + 4'd1;
              end
              if ((com_cnt + 4'd1) == LOCK_N) begin
                state_n = ACTIVE;
              end
            end else begin
              com_cnt_n = 4'd0;
              state_n   = SEARCH;
            end
          end
        end

        ACTIVE: begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (byte_end) begin
            data_out_n  = nxt;
            valid_out_n = !is_com;
            com_det_n   = is_com;
          end
        end

        default: begin
          state_n = SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_serial_to_parallel.sv
// Self-checking bench for rx_serial_to_parallel: bytes are driven serially,
// expected pulses are queued with their due cycle and matched by a monitor.
module tb_rx_serial_to_parallel;
  import phy_rx_pkg::*;

  localparam int K_NONE = 0;
  localparam int K_DATA = 1;
  localparam int K_COM  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b0;
  logic       data_in_en = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       com_det;
  logic       active;

  rx_serial_to_parallel #(
    .COM_SYMBOL     (8'hBC),
    .COM_LOCK_COUNT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_in_en (data_in_en),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .com_det    (com_det),
    .active     (active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_com;
    logic [7:0] data;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         kind;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   pulses = 0;
  int   last_pulse = 0;
  int   prev_pulse = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (valid_out || com_det)) begin
      exp_t e;
      pulses++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got valid=%0b com=%0b data=%02h at cyc %0d, expected none",
                 valid_out, com_det, data_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (valid_out == !e.is_com && com_det == e.is_com && data_out == e.data && cyc == e.due)
          passes++;
        else
          $display("FAIL pulse: got valid=%0b com=%0b data=%02h cyc=%0d, expected com=%0b data=%02h cyc=%0d",
                   valid_out, com_det, data_out, cyc, e.is_com, e.data, e.due);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_in    = b;
    data_in_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int kind, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      data_in    = b[i];
      data_in_en = 1'b1;
      if (i == 0 && kind != K_NONE) exp_q.push_back('{(kind == K_COM), b, cyc + 1});
      if (gap) begin
        @(negedge clk);
        data_in_en = 1'b0;
        data_in    = 1'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in_en = 1'b0;
      data_in    = 1'b0;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset      = 1'b1;
    data_in_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{8'hBC, K_COM};
    vecs[1] = '{8'hEE, K_DATA};
    vecs[2] = '{8'h00, K_DATA};
    vecs[3] = '{8'hBC, K_COM};
    vecs[4] = '{8'h7E, K_DATA};
    vecs[5] = '{8'hBC, K_COM};
    vecs[6] = '{8'hBC, K_COM};
    vecs[7] = '{8'h81, K_DATA};

    // Reset values
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", valid_out, 0);
    check("rst_com_det", com_det, 0);
    check("rst_active", active, 0);
    @(negedge clk);
    reset = 1'b0;

    // 16 zero bits: nothing happens
    send_byte(8'h00, K_NONE, 0);
    send_byte(8'h00, K_NONE, 0);
    settle();
    check("zeros_active", active, 0);
    check("zeros_data_out", data_out, 8'h00);
    check("zeros_no_pulse", pulses, 0);

    // Junk bits then lock on 4 COMs, then FF, DD back to back
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'hBC, K_NONE, 0);
    settle();
    check("lock_before_4th", active, 0);
    send_byte(8'hBC, K_NONE, 0);
    settle();
    check("lock_after_4th", active, 1);
    send_byte(8'hFF, K_DATA, 0);
    send_byte(8'hDD, K_DATA, 0);
    idle(2);
    check("ff_dd_spacing", last_pulse - prev_pulse, 8);
    check("ff_dd_data_out", data_out, 8'hDD);
    check("ff_dd_queue", exp_q.size(), 0);

    // Table of ACTIVE bytes, continuous enable
    for (int i = 0; i < 8; i++) send_byte(vecs[i].data, vecs[i].kind, 0);
    idle(2);
    check("table_data_out", data_out, 8'h81);
    check("table_queue", exp_q.size(), 0);
    check("table_active", active, 1);

    // A non-COM during ALIGN drops back to SEARCH
    pulse_reset();
    send_byte(8'hBC, K_NONE, 0);
    send_byte(8'hBC, K_NONE, 0);
    send_byte(8'h55, K_NONE, 0);
    settle();
    check("realign_after_55", active, 0);
    for (int i = 0; i < 3; i++) send_byte(8'hBC, K_NONE, 0);
    settle();
    check("realign_before_4th", active, 0);
    send_byte(8'hBC, K_NONE, 0);
    settle();
    check("realign_after_4th", active, 1);
    send_byte(8'hCC, K_DATA, 0);
    idle(2);
    check("realign_data_out", data_out, 8'hCC);
    check("realign_queue", exp_q.size(), 0);

    // Enable on alternate cycles
    pulse_reset();
    for (int i = 0; i < 4; i++) send_byte(8'hBC, K_NONE, 1);
    settle();
    check("gap_active", active, 1);
    send_byte(8'hAA, K_DATA, 1);
    send_byte(8'hAA, K_DATA, 1);
    idle(2);
    check("gap_spacing", last_pulse - prev_pulse, 16);
    check("gap_data_out", data_out, 8'hAA);
    check("gap_queue", exp_q.size(), 0);

    // Asynchronous reset mid-byte while ACTIVE
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(posedge clk);
    #2;
    reset      = 1'b1;
    data_in_en = 1'b0;
    #1;
    check("async_rst_data_out", data_out, 8'h00);
    check("async_rst_valid", valid_out, 0);
    check("async_rst_com_det", com_det, 0);
    check("async_rst_active", active, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hBC, K_NONE, 0);
    settle();
    check("relock_before_4th", active, 0);
    send_byte(8'hBC, K_NONE, 0);
    settle();
    check("relock_after_4th", active, 1);
    send_byte(8'h3C, K_DATA, 0);
    idle(3);
    check("relock_data_out", data_out, 8'h3C);
    check("final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
